// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per clock, with a one-cycle done pulse and a held result.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  // Handshake: start is a one-cycle request taken only while busy=0; done is a
  // one-cycle pulse during which result is valid; result is held afterwards.
  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               neg_a, neg_b;

  // Issue-side decode of the incoming request
  logic             accept, is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] mag_a, mag_b, spec_res;

  always_comb begin
    accept    = start && (state != CALC);
    is_div_in = op[2];
    a_sgn_in  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn_in  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg_in  = a_sgn_in && A[WIDTH-1];
    b_neg_in  = b_sgn_in && B[WIDTH-1];
    mag_a     = a_neg_in ? -A : A;
    mag_b     = b_neg_in ? -B : B;
    div_zero  = is_div_in && (B == '0);
    div_ovf   = is_div_in && !op[0] && (A == MIN_NEG) && (B == '1);
    special   = div_zero || div_ovf;
    spec_res  = '0;
    if (div_zero)     spec_res = op[1] ? A : '1;
    else if (div_ovf) spec_res = op[1] ? '0 : A;
  end

  // One iteration step for both engines; acc holds {hi, lo} or {remainder, quotient}
  logic [WIDTH:0]   add_sum, rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    borrow  = rem_sh < {1'b0, opnd};
    diff    = rem_sh[WIDTH-1:0] - opnd;
    if (op_q[2]) begin
      acc_nxt = borrow ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                       : {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection applied to the final iteration
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, calc_res;

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    quo_fix  = (neg_a ^ neg_b) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem_fix  = neg_a ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                   calc_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011:   calc_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:           calc_res = quo_fix;
      default:                  calc_res = rem_fix;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (start) state_nxt = special ? FIN : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      op_q   <= '0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      neg_a <= a_neg_in;
      neg_b <= b_neg_in;
      cnt   <= '0;
      acc   <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
      opnd  <= is_div_in ? mag_b : mag_a;
      if (special) result <= spec_res;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) result <= calc_res;
    end
  end

  assign busy      = (state == CALC);
  assign done      = (state == FIN);
  assign dbg_state = state;

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Parametrised, iterative multiply/divide unit that extends the single-cycle integer ALU with the RV32M operations. It sits beside the ALU in the execute stage. It takes operands and an operation code on a one-cycle `start` pulse and runs a shift-add multiplier or a restoring divider, one bit per clock. It holds `busy` while iterating and returns the result with a one-cycle `done` pulse, so the control unit can stall the pipeline while it runs.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be ≥ 4.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge
- `RST_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  3  operation, RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `A`  in  WIDTH  rs1 operand, sampled with `start`
- `B`  in  WIDTH  rs2 operand, sampled with `start`
- `busy`  out  1  iteration in progress
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  WIDTH  last completed result; held until the next completion

## Operation
- FSM states: IDLE, CALC, FIN.
- **Reset** (asynchronous, `RST_n`=0):
  - state ← IDLE; `busy`=0, `done`=0, `result`=0.
  - Counter and internal registers ← 0.
  - Applies at any time, including mid-CALC; the operation in flight is discarded and no `done` is produced.
- **IDLE or FIN, `start`=1:** latch `op`, `A` and `B`.
  - Record the operand signs: A signed for MULH, MULHSU, DIV, REM; B signed for MULH, DIV, REM.
  - Convert the signed operands to magnitudes.
  - Special cases (below) go directly to FIN; otherwise go to CALC with the counter at 0.
- **CALC, multiply:** each cycle, if the current multiplier LSB is 1, add the multiplicand into the upper half of a 2·WIDTH accumulator; then shift right by 1.
- **CALC, divide:** restoring division.
  - Each cycle, shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor from the remainder.
  - If there is no borrow, keep the difference and set the quotient LSB.
- After WIDTH iterations, go to FIN.
- **Sign fix:** negate the product (2·WIDTH bits) if the operand signs differ. Negate the quotient if the dividend and divisor signs differ. Give the remainder the sign of the dividend.
- **Result selection:**
  - MUL: low WIDTH bits of the product; MULH, MULHSU, MULHU: high WIDTH bits.
  - DIV, DIVU: quotient; REM, REMU: remainder.
- **FIN:** `done`=1 and `result` is updated for exactly this cycle. The next state is IDLE, or CALC/FIN if `start`=1 in the same cycle (back-to-back issue).
- **Special cases** (resolved without iterating):
  - Divide by zero (B=0): DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow (DIV/REM with A = 1 followed by WIDTH−1 zeros and B = all ones): DIV → A; REM → 0.
- `start` in CALC is ignored; it is not queued.
- `op` values are fully decoded; there is no illegal encoding.

## Timing
- Take `start` sampled at rising edge E0.
- **Normal operation:**
  - `busy`=1 in the cycles following edges E0 … E(WIDTH−1), i.e. WIDTH cycles.
  - `done`=1 in the cycle following edge E(WIDTH); latency is WIDTH+1 cycles.
  - `result` changes at edge E(WIDTH) and is held thereafter.
- **Special cases:** `done`=1 in the cycle following E0 (latency 1); `busy` stays 0.
- `busy` and `done` are never 1 in the same cycle.
- **Back-to-back issue:** `start` during the `done` cycle is accepted. The next `busy` begins in the following cycle, so throughput is one operation per WIDTH+1 cycles.
- **Boundary conditions:**
  - The counter is log2(WIDTH)+1 bits; it must not wrap before the FIN transition.
  - Reset asserted in the same cycle as `start` wins.

## Test plan
Scenarios use WIDTH=32.
- MUL 7 × 0xFFFFFFFD (−3): `start` at E0 → `done` in the cycle after E32 with `result`=0xFFFFFFEB; `busy` high for exactly 32 cycles.
- High-half multiplies → required results:
  - MULH 0x80000000 × 0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF
- Divides → required results:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF
  - DIVU 100/7 → 14; REMU 100/7 → 2
  - REM 7/−2 → 1
- Special cases, each with `done` one cycle after `start` and `busy` never asserted:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM 0x80000000/0xFFFFFFFF → 0
- **Issue control:**
  - `start` pulsed again at E10 of a DIVU with different operands → ignored; first result unchanged.
  - `start` during the `done` cycle → second operation completes 33 cycles later with the correct value.
- **Reset mid-operation:** `RST_n` low at E15 of a MUL → `busy`, `done` and `result` go to 0 immediately, with no `done` pulse afterwards. After release, a new MUL 3×4 returns 12.
